// File: rtl/pipe_skid_stage.sv
// Pipeline stage boundary register with a 2-entry skid buffer.
// Upstream ready depends only on held state, never on out_ready, so stages can
// be chained without building long ready chains. Also tracks halt entries,
// supports a synchronous flush and counts back-pressure cycles.
module pipe_skid_stage #(
    parameter int unsigned DATA_W          = 64,
    parameter int unsigned CLEAR_ON_BUBBLE = 1,
    parameter int unsigned CNT_W           = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_halt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_halt,
    output logic              halt_done,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic             CLR_BUB = (CLEAR_ON_BUBBLE != 0);

    // Main (head) entry and skid entry
    logic              mv;
    logic [DATA_W-1:0] m_data;
    logic              m_halt;
    logic              sv;
    logic [DATA_W-1:0] s_data;
    logic              s_halt;
    logic              halt_pend;
    logic              halt_done_q;
    logic [CNT_W-1:0]  stall_q;

    logic acc;
    logic deq;

    // Handshake events; in_ready is a pure function of flops
    always_comb begin
        in_ready  = !sv && !halt_pend && !halt_done_q;
        acc       = in_valid && in_ready;
        deq       = mv && out_ready;
        out_valid = mv;
        out_data  = m_data;
        out_halt  = m_halt;
        occupancy = 2'(mv) + 2'(sv);
        halt_done = halt_done_q;
        stall_cnt = stall_q;
    end

    // Entry storage, halt tracking and flush
    always_ff @(posedge CLK) begin
        if (RST) begin
            mv          <= 1'b0;
            sv          <= 1'b0;
            m_data      <= '0;
            m_halt      <= 1'b0;
            s_data      <= '0;
            s_halt      <= 1'b0;
            halt_pend   <= 1'b0;
            halt_done_q <= 1'b0;
        end else if (flush) begin
            // A same-cycle dequeue has still left the stage downstream
            if (deq && m_halt) begin
                halt_done_q <= 1'b1;
            end
            mv        <= 1'b0;
            sv        <= 1'b0;
            halt_pend <= 1'b0;
            if (CLR_BUB) begin
                m_data <= '0;
                m_halt <= 1'b0;
                s_data <= '0;
                s_halt <= 1'b0;
            end
        end else begin
            if (deq && sv) begin
                // Skid entry moves to head; in_ready was low so no accept
                m_data <= s_data;
                m_halt <= s_halt;
                sv     <= 1'b0;
                if (CLR_BUB) begin
                    s_data <= '0;
                    s_halt <= 1'b0;
                end
            end else if (deq && acc) begin
                m_data <= in_data;
                m_halt <= in_halt;
            end else if (deq) begin
                mv <= 1'b0;
                if (CLR_BUB) begin
                    m_data <= '0;
                    m_halt <= 1'b0;
                end
            end else if (acc && !mv) begin
                m_data <= in_data;
                m_halt <= in_halt;
                mv     <= 1'b1;
            end else if (acc) begin
                s_data <= in_data;
                s_halt <= in_halt;
                sv     <= 1'b1;
            end

            if (acc && in_halt) begin
                halt_pend <= 1'b1;
            end
            if (deq && m_halt) begin
                halt_pend   <= 1'b0;
                halt_done_q <= 1'b1;
            end
        end
    end

    // Saturating count of cycles the head entry is held back
    always_ff @(posedge CLK) begin
        if (RST || stall_clr) begin
            stall_q <= '0;
        end else if (mv && !out_ready && (stall_q != CNT_MAX)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised successor to the fixed-field pipeline latches between CPU stages (e.g. MEM/WB).
- Carries an opaque payload of configurable width with a valid/ready handshake.
- Holds a 2-entry skid buffer so upstream ready is fully registered, with no combinational path from out_ready.
- Adds synchronous flush, sticky halt tracking, bubble clearing and a saturating back-pressure counter.
- Instantiated once per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) with the stage's packed struct as payload.

Parameters:
- DATA_W, 64: payload width in bits; must be ≥ 1.
- CLEAR_ON_BUBBLE, 1: 1 = payload registers are zeroed whenever their valid bit is cleared; 0 = payload registers hold their stale value.
- CNT_W, 16: width of the stall counter; must be ≥ 1.

Ports:
- CLK, input, 1: clock; all state updates on the rising edge.
- RST, input, 1: synchronous, active-high reset.
- flush, input, 1: synchronous discard of all held entries.
- in_valid, input, 1: upstream entry present.
- in_ready, output, 1: stage can accept an entry; driven only from flops.
- in_data, input, DATA_W: upstream payload.
- in_halt, input, 1: entry is a halt instruction.
- out_valid, output, 1: head entry present.
- out_ready, input, 1: downstream accepts the head entry.
- out_data, output, DATA_W: head payload.
- out_halt, output, 1: head entry is a halt.
- halt_done, output, 1: sticky; a halt entry has left the stage.
- occupancy, output, 2: number of held entries (0..2).
- stall_cnt, output, CNT_W: cycles with out_valid && !out_ready.
- stall_clr, input, 1: synchronous clear of stall_cnt.

Behaviour:
- State:
  - Main entry M with {mv, M.data, M.halt}.
  - Skid entry S with {sv, S.data, S.halt}.
  - halt_pend: halt accepted but not yet delivered.
  - halt_done.
  - stall counter.
- Reset (RST=1): mv=sv=0, all data/halt bits 0, halt_pend=0, halt_done=0, stall_cnt=0.
  - Outputs after reset: out_valid=0, out_data=0, out_halt=0, occupancy=0, in_ready=1.
  - RST overrides flush and all handshakes in the same cycle.
- Combinational outputs from state:
  - out_valid=mv, out_data=M.data, out_halt=M.halt.
  - occupancy=mv+sv.
  - in_ready = !sv && !halt_pend && !halt_done.
- Handshake events: acc = in_valid && in_ready; deq = mv && out_ready.
- Latency and throughput: 1 cycle from an accepted input to out_valid when the stage is empty; sustained 1 entry/cycle when out_ready=1.
- Priority of next-state update each cycle: RST > flush > normal.
- Normal update:
  - deq && sv: M<=S, sv<=0. No acc is possible here because in_ready=0.
  - deq && !sv && acc: M<=in.
  - deq && !sv && !acc: mv<=0.
  - !deq && acc && !mv: M<=in, mv<=1.
  - !deq && acc && mv: S<=in, sv<=1.
  - Otherwise: hold.
- Halt tracking:
  - acc && in_halt sets halt_pend. Entries after a halt are never accepted.
  - deq && M.halt clears halt_pend and sets halt_done.
  - halt_done holds until RST.
- Flush:
  - Sets mv=sv=0 and clears halt_pend; an acc in the same cycle is dropped.
  - A deq in the same cycle still counts as taken downstream. If that deq carries a halt, halt_done is set.
  - halt_done is not cleared by flush.
- Bubble clearing: with CLEAR_ON_BUBBLE=1, any register whose valid bit is cleared (deq, flush, reset) also has its data and halt zeroed in the same edge.
- stall_cnt:
  - Next value: 0 if stall_clr or RST; otherwise +1 when mv && !out_ready.
  - Saturates at 2^CNT_W−1 with no wrap.
  - stall_clr has priority over increment.
- occupancy is never 3. Accepting while sv=1 is impossible by construction; the bench asserts this.

Test Plan:
1. Streaming: RST 1 cycle, then in_valid=1 with data 0x1..0x8 on consecutive cycles, out_ready=1 -> out_data 0x1..0x8 one cycle later each; occupancy ≤ 1; stall_cnt=0.
2. Skid fill: send 0xA, 0xB with out_ready=0 -> occupancy=2, in_ready=0 on the cycle after 0xB is accepted; raise out_ready -> 0xA then 0xB delivered; in_ready returns to 1 when sv clears; stall_cnt counts the held cycles exactly.
3. Halt: send 0x10, then 0x11 with in_halt=1, then 0x12 -> 0x12 is never accepted (in_ready=0 from the cycle after the halt is accepted); after the halt is dequeued, halt_done=1 and stays 1 for 20 further cycles.
4. Flush with simultaneous input: occupancy=2, then flush=1 with in_valid=1 -> next cycle out_valid=0, occupancy=0, out_data=0 (CLEAR_ON_BUBBLE=1); the dropped input never appears.
5. Counter saturation, with CNT_W=4: hold mv=1 and out_ready=0 for 20 cycles -> stall_cnt=15 and held there; stall_clr=1 for 1 cycle -> 0.
6. Reset mid-operation: RST with occupancy=2 and halt_pend=1 -> next cycle all outputs at their reset values and in_ready=1.
